// File: rtl/ultrasonido_pkg.sv
// Shared definitions for the ultrasonic ranger: FSM state encoding,
// default timing constants and a small constant helper.
package ultrasonido_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TRIGGER  = 3'd1,
    ST_WAIT     = 3'd2,
    ST_WAITECHO = 3'd3,
    ST_DONE     = 3'd4,
    ST_GUARD    = 3'd5
  } state_e;

  localparam int unsigned DEF_CLK_DIV    = 50;
  localparam int unsigned DEF_N_CH       = 2;
  localparam int unsigned DEF_TRIG_US    = 10;
  localparam int unsigned DEF_TW         = 15;
  localparam int unsigned DEF_TIMEOUT_US = 30000;
  localparam int unsigned DEF_GUARD_US   = 60000;
  localparam int unsigned DEF_THRESH_US  = 1000;
  localparam int unsigned DEF_CNT_W      = 8;

  // Largest of three constants; sizes the shared tick counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running prescaler: emits a one-clk tick every CLK_DIV clk cycles.
module us_tick_gen #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == PW'(CLK_DIV - 1));

  // Next count: wrap to zero on the tick cycle.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + PW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ultrasonic_ranger.sv
// Round-robin multi-channel ultrasonic ranger. Fires a trigger pulse on
// one channel, times the echo in 1 us ticks, reports the result with a
// one-cycle valid strobe, updates the per-channel near flag and event
// counter, then holds off before moving to the next channel.
//
// Handshake: valid is a one-cycle strobe with no back-pressure; Tiempo,
// canal and timeout_err change only in the cycle valid is high and hold
// their value until the next strobe.
module ultrasonic_ranger
  import ultrasonido_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned N_CH       = DEF_N_CH,
  parameter int unsigned TRIG_US    = DEF_TRIG_US,
  parameter int unsigned TW         = DEF_TW,
  parameter int unsigned TIMEOUT_US = DEF_TIMEOUT_US,
  parameter int unsigned GUARD_US   = DEF_GUARD_US,
  parameter int unsigned THRESH_US  = DEF_THRESH_US,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      Enable,
  input  logic [N_CH-1:0]                           Echo,
  output logic [N_CH-1:0]                           Trigger,
  output logic [TW-1:0]                             Tiempo,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] canal,
  output logic                                      valid,
  output logic                                      timeout_err,
  output logic [N_CH-1:0]                           Led,
  output logic [N_CH*CNT_W-1:0]                     contador_eventos,
  output state_e                                    dbg_state
);

  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned MAX_T = max3(TRIG_US, TIMEOUT_US, GUARD_US);
  localparam int unsigned CW    = $clog2(MAX_T + 1);

  logic tick;

  us_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  state_e          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [CW-1:0]   tcnt_q, tcnt_d;
  logic [N_CH-1:0] trigger_q, trigger_d;
  logic [TW-1:0]   tiempo_q, tiempo_d;
  logic [CH_W-1:0] canal_q, canal_d;
  logic            valid_q, valid_d;
  logic            terr_q, terr_d;

  logic [N_CH-1:0] echo_s;
  logic [N_CH-1:0] echo_prev;
  logic            echo_cur, rise, fall;
  logic            fin, fin_to, near;
  logic [TW-1:0]   fin_t;

  assign echo_cur = echo_s[ch_q];
  assign rise     = echo_cur & ~echo_prev[ch_q];
  assign fall     = ~echo_cur & echo_prev[ch_q];

  // Next-state, tick counter and result capture for the measurement FSM.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    tcnt_d  = tcnt_q;
    fin     = 1'b0;
    fin_to  = 1'b0;
    fin_t   = '0;
    case (state_q)
      ST_IDLE: begin
        if (tick && Enable) begin
          state_d = ST_TRIGGER;
          tcnt_d  = '0;
        end
      end
      ST_TRIGGER: begin
        if (tick) begin
          if (tcnt_q == CW'(TRIG_US - 1)) begin
            state_d = ST_WAIT;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + CW'(1);
          end
        end
      end
      ST_WAIT: begin
        // An echo already high on entry has echo_prev set, so it never
        // looks like a rising edge here.
        if (rise) begin
          state_d = ST_WAITECHO;
          // The first high cycle is spent here; count its tick too.
          tcnt_d  = tick ? CW'(1) : '0;
        end else if (tick) begin
          if (tcnt_q == CW'(TIMEOUT_US - 1)) begin
            state_d = ST_DONE;
            fin     = 1'b1;
            fin_to  = 1'b1;
          end else begin
            tcnt_d = tcnt_q + CW'(1);
          end
        end
      end
      ST_WAITECHO: begin
        if (fall) begin
          state_d = ST_DONE;
          fin     = 1'b1;
          fin_t   = TW'(tcnt_q);
        end else if (tick && echo_cur) begin
          if (tcnt_q == CW'(TIMEOUT_US - 1)) begin
            state_d = ST_DONE;
            fin     = 1'b1;
            fin_to  = 1'b1;
            fin_t   = TW'(TIMEOUT_US);
          end else begin
            tcnt_d = tcnt_q + CW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_GUARD;
        tcnt_d  = '0;
      end
      ST_GUARD: begin
        if (tick) begin
          if (tcnt_q == CW'(GUARD_US - 1)) begin
            ch_d    = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);
            tcnt_d  = '0;
            state_d = Enable ? ST_TRIGGER : ST_IDLE;
          end else begin
            tcnt_d = tcnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tcnt_d  = '0;
      end
    endcase

    near = ~fin_to && (fin_t < TW'(THRESH_US));

    trigger_d = '0;
    if (state_d == ST_TRIGGER) trigger_d[ch_d] = 1'b1;

    valid_d  = fin;
    tiempo_d = fin ? fin_t  : tiempo_q;
    canal_d  = fin ? ch_q   : canal_q;
    terr_d   = fin ? fin_to : terr_q;
  end

  // FSM and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      tcnt_q    <= '0;
      trigger_q <= '0;
      tiempo_q  <= '0;
      canal_q   <= '0;
      valid_q   <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      tcnt_q    <= tcnt_d;
      trigger_q <= trigger_d;
      tiempo_q  <= tiempo_d;
      canal_q   <= canal_d;
      valid_q   <= valid_d;
      terr_q    <= terr_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic             s1_q, s2_q, prev_q;
    logic             led_q, led_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             upd;

    // Near flag and saturating near-zone entry counter for this channel;
    // a timed-out measurement leaves both untouched.
    always_comb begin
      upd   = fin && ~fin_to && (ch_q == CH_W'(k));
      led_d = upd ? near : led_q;
      cnt_d = cnt_q;
      if (upd && near && ~led_q && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    // Two-flop echo synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        prev_q <= 1'b0;
        led_q  <= 1'b0;
        cnt_q  <= '0;
      end else begin
        s1_q   <= Echo[k];
        s2_q   <= s1_q;
        prev_q <= s2_q;
        led_q  <= led_d;
        cnt_q  <= cnt_d;
      end
    end

    assign echo_s[k]    = s2_q;
    assign echo_prev[k] = prev_q;
    assign Led[k]       = led_q;
    assign contador_eventos[k*CNT_W +: CNT_W] = cnt_q;
  end

  assign Trigger     = trigger_q;
  assign Tiempo      = tiempo_q;
  assign canal       = canal_q;
  assign valid       = valid_q;
  assign timeout_err = terr_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/ultrasonic_ranger.md
ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

Interface
REQ-001 Parameter CLK_DIV, 50, clk cycles per 1 us tick (clk = 50 MHz).
REQ-002 Parameter N_CH, 2, number of sensor channels, 1..8.
REQ-003 Parameter TRIG_US, 10, trigger pulse width in ticks.
REQ-004 Parameter TW, 15, width of time-of-flight value.
REQ-005 Parameter TIMEOUT_US, 30000, maximum wait or echo time in ticks; must be < 2^TW.
REQ-006 Parameter GUARD_US, 60000, holdoff between measurements in ticks, per channel switch.
REQ-007 Parameter THRESH_US, 1000, "near" threshold in ticks.
REQ-008 Parameter CNT_W, 8, per-channel event counter width.
REQ-009 Port clk, input, 1, single clock; all logic is on its rising edge.
REQ-010 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-011 Port Enable, input, 1, run continuous round-robin measurements.
REQ-012 Port Echo, input, N_CH, asynchronous echo per channel.
REQ-013 Port Trigger, output, N_CH, trigger pulse per channel.
REQ-014 Port Tiempo, output, TW, last measured time in ticks.
REQ-015 Port canal, output, clog2(N_CH) (min 1), channel of Tiempo.
REQ-016 Port valid, output, 1, one-cycle strobe: Tiempo/canal/timeout_err updated.
REQ-017 Port timeout_err, output, 1, last measurement timed out.
REQ-018 Port Led, output, N_CH, per-channel near flag.
REQ-019 Port contador_eventos, output, N_CH*CNT_W, packed event counters; channel k at bits [k*CNT_W +: CNT_W].

Function
REQ-020 A free-running prescaler shall emit a one-clk tick every CLK_DIV clk; all timing counts ticks, and no logic is clocked by a derived clock.
REQ-021 Each Echo bit shall pass a 2-flop synchroniser before use.
REQ-022 FSM states: IDLE, TRIGGER, WAIT, WAITECHO, DONE, GUARD.
REQ-023 IDLE -> TRIGGER on the first tick with Enable=1; the tick counter clears on entry.
REQ-024 TRIGGER: Trigger[ch]=1 for exactly TRIG_US ticks, then -> WAIT; all other Trigger bits stay 0.
REQ-025 WAIT -> WAITECHO on a synchronised Echo[ch] rising edge; WAIT -> DONE with timeout if TIMEOUT_US ticks elapse first.
REQ-026 If Echo[ch] is already high on entry to WAIT, it shall not count as a rising edge.
REQ-027 WAITECHO: the time counter increments per tick while Echo[ch] is high.
REQ-028 WAITECHO -> DONE on the synchronised falling edge.
REQ-029 WAITECHO -> DONE with timeout when the count reaches TIMEOUT_US; Tiempo is then TIMEOUT_US.
REQ-030 DONE lasts 1 clk and asserts valid.
REQ-031 In DONE, Tiempo, canal and timeout_err update in the same cycle as valid.
REQ-032 A WAIT timeout reports Tiempo=0.
REQ-033 In DONE, Led[ch] = (!timeout && Tiempo < THRESH_US).
REQ-034 contador_eventos[ch] increments when Led[ch] goes 0->1 in DONE (entry into near zone) and saturates at all-ones.
REQ-035 GUARD waits GUARD_US ticks. It then advances ch = (ch+1) mod N_CH, and goes -> TRIGGER if Enable=1, else -> IDLE.
REQ-036 Enable deasserted mid-measurement shall not abort the measurement; the current measurement and GUARD complete first.
REQ-037 A channel with timeout keeps its previous Led value unchanged.

Reset
REQ-038 While rst_n=0: state=IDLE, ch=0, prescaler=0, synchronisers=0, and the following outputs are 0: Trigger, Tiempo, canal, valid, timeout_err, Led, contador_eventos.
REQ-039 Reset asserted mid-pulse shall drop Trigger in the same cycle (asynchronous).
REQ-040 After reset release, the first trigger is on channel 0.

Structure
REQ-041 State encoding and default timing constants live in shared package ultrasonido_pkg.
REQ-042 One sub-module, us_tick_gen (prescaler emitting tick), is instantiated once.
REQ-043 Echo synchronisers and per-channel counters are generate loops over N_CH.

Verification
REQ-044 With N_CH=2 and Enable=1: Trigger[0] is high exactly 10 ticks (500 clk); Echo[0] high 580 us -> valid with Tiempo=580, canal=0, Led[0]=1, contador_eventos[0]=1.
REQ-045 Same channel, next echo 700 us -> contador_eventos[0] stays 1; next echo 1200 us -> Led[0]=0; next echo 900 us -> counter becomes 2.
REQ-046 Echo[1] never rises -> after 30000 ticks valid with timeout_err=1, Tiempo=0, Led[1] unchanged.
REQ-047 Echo[0] stuck high 40000 us -> Tiempo=30000, timeout_err=1; an echo already high at WAIT entry is not counted.
REQ-048 CNT_W=2 with 5 near entries -> counter holds at 3.
REQ-049 rst_n pulsed low during TRIGGER -> Trigger=0 immediately; all outputs are 0; after release the next measurement starts on channel 0.
